// File: rtl/timer_pkg.sv
// Shared definitions for the 32-bit timer command interface.
// Command word layout: [31:30] opcode, [29:0] operand.
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_SET_INIT  = 2'b00,
    TMR_SET_PRESC = 2'b01,
    TMR_DISABLE   = 2'b10,
    TMR_ENABLE    = 2'b11
  } tmr_op_e;

  localparam int TMR_EXPIRED_BIT = 0;

  function automatic logic [31:0] tmr_word(tmr_op_e op, logic [29:0] operand);
    return {op, operand};
  endfunction

endpackage

// File: rtl/timer_cmd_seq.sv
// Timer command initiator: programs the timer for one {init, prescaler} request,
// measures cycles to expiry and returns the result over a valid/ready response port.
module timer_cmd_seq
  import timer_pkg::*;
#(
  parameter int PRESC_W = 5,
  parameter int CNT_W   = 64,
  parameter int SLACK   = 16,
  parameter int DIS_CYC = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [29:0]        req_init,
  input  logic [PRESC_W-1:0] req_presc,
  output logic [31:0]        tmr_cmd,
  input  logic [31:0]        tmr_status,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [CNT_W-1:0]   rsp_cycles,
  output logic [CNT_W-1:0]   rsp_expected,
  output logic               rsp_match,
  output logic               rsp_timeout
);

  generate
    if (CNT_W < 30 + 2**PRESC_W - 1) begin : g_cnt_w_chk
      $error("timer_cmd_seq: CNT_W too small for init << presc");
    end
    if (DIS_CYC < 1) begin : g_dis_chk
      $error("timer_cmd_seq: DIS_CYC must be at least 1");
    end
  endgenerate

  localparam int DIS_W = (DIS_CYC > 1) ? $clog2(DIS_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_DIS, S_LD_INIT, S_LD_PRESC, S_ENA, S_RUN, S_RESP
  } state_e;

  state_e             state;
  logic [DIS_W-1:0]   dis_cnt;
  logic [29:0]        init_q;
  logic [PRESC_W-1:0] presc_q;
  logic [CNT_W-1:0]   exp_q;
  logic [CNT_W-1:0]   limit_q;
  logic [CNT_W-1:0]   cnt;

  logic expired;
  logic status_unused;
  assign expired       = tmr_status[TMR_EXPIRED_BIT];
  assign status_unused = ^tmr_status[31:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      dis_cnt      <= '0;
      init_q       <= '0;
      presc_q      <= '0;
      exp_q        <= '0;
      limit_q      <= '0;
      cnt          <= '0;
      req_ready    <= 1'b1;
      tmr_cmd      <= tmr_word(TMR_DISABLE, '0);
      rsp_valid    <= 1'b0;
      rsp_cycles   <= '0;
      rsp_expected <= '0;
      rsp_match    <= 1'b0;
      rsp_timeout  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          init_q    <= req_init;
          presc_q   <= req_presc;
          exp_q     <= CNT_W'(req_init) << req_presc;
          limit_q   <= (CNT_W'(req_init) << req_presc) + CNT_W'(SLACK);
          dis_cnt   <= '0;
          req_ready <= 1'b0;
          tmr_cmd   <= tmr_word(TMR_DISABLE, '0);
          state     <= S_DIS;
        end
        S_DIS: begin
          // Holding DISABLE clears any done flag left from the previous run.
          if (dis_cnt == DIS_W'(DIS_CYC - 1)) begin
            tmr_cmd <= tmr_word(TMR_SET_INIT, init_q);
            state   <= S_LD_INIT;
          end else begin
            dis_cnt <= dis_cnt + 1'b1;
          end
        end
        S_LD_INIT: begin
          tmr_cmd <= tmr_word(TMR_SET_PRESC, 30'(presc_q));
          state   <= S_LD_PRESC;
        end
        S_LD_PRESC: begin
          tmr_cmd <= tmr_word(TMR_ENABLE, '0);
          state   <= S_ENA;
        end
        S_ENA: begin
          cnt   <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          // Expiry is checked first so a same-cycle expiry beats the timeout.
          if (expired || cnt == limit_q) begin
            rsp_cycles   <= cnt;
            rsp_expected <= exp_q;
            rsp_timeout  <= !expired;
            rsp_match    <= expired && (cnt == exp_q);
            rsp_valid    <= 1'b1;
            state        <= S_RESP;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_cmd_seq.sv
// Directed bench for timer_cmd_seq with a stub timer and a result model.
module tb_timer_cmd_seq;

  localparam int PRESC_W = 5;
  localparam int CNT_W   = 64;
  localparam int SLACK   = 16;
  localparam logic [31:0] NEVER = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic [29:0]        req_init = '0;
  logic [PRESC_W-1:0] req_presc = '0;
  logic [31:0]        tmr_cmd;
  logic [31:0]        tmr_status;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [CNT_W-1:0]   rsp_cycles;
  logic [CNT_W-1:0]   rsp_expected;
  logic               rsp_match;
  logic               rsp_timeout;

  int n_chk  = 0;
  int n_fail = 0;

  timer_cmd_seq #(.PRESC_W(PRESC_W), .CNT_W(CNT_W), .SLACK(SLACK), .DIS_CYC(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_init(req_init), .req_presc(req_presc),
    .tmr_cmd(tmr_cmd), .tmr_status(tmr_status),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_cycles(rsp_cycles), .rsp_expected(rsp_expected),
    .rsp_match(rsp_match), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // Stub timer: expires once it has seen more than stub_n enabled cycles.
  logic [31:0] stub_n = NEVER;
  logic        stub_stale = 1'b0;
  logic [31:0] t_cnt = '0;
  logic        ena;
  assign ena = (tmr_cmd[31:30] == 2'b11);
  always @(posedge clk) begin
    if (!ena) t_cnt <= '0;
    else if (t_cnt != '1) t_cnt <= t_cnt + 1;
  end
  assign tmr_status = {31'b0, (stub_stale && !ena) || (ena && t_cnt > stub_n)};

  typedef struct packed {
    logic [63:0] cycles;
    logic [63:0] expected;
    logic        timeout;
    logic        match;
  } rsp_t;

  rsp_t exp_q[$];

  // Result from the rules: expiry after n ticks, bounded by expected+SLACK.
  function automatic rsp_t model(logic [29:0] init, logic [4:0] presc, logic [31:0] n);
    rsp_t r;
    logic [63:0] lim;
    r.expected = 64'(init) << presc;
    lim = r.expected + 64'(SLACK);
    if (64'(n) <= lim) begin r.cycles = 64'(n); r.timeout = 1'b0; end
    else begin r.cycles = lim; r.timeout = 1'b1; end
    r.match = !r.timeout && (r.cycles == r.expected);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  // Per-cycle response check against the model queue.
  initial begin
    rsp_t r;
    forever begin
      @(negedge clk); #1;
      if (reset_n && rsp_valid) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          r = exp_q[0];
          chk("rsp_fields", {rsp_cycles, rsp_expected, rsp_timeout, rsp_match}, r);
          chk("req_ready_in_resp", req_ready, 0);
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_req(input logic [29:0] init, input logic [4:0] presc, output bit ok);
    int w;
    ok = 0;
    w = 0;
    while (!req_ready && w < 40) begin @(negedge clk); w++; end
    if (!req_ready) begin chk("req_ready_wait", 0, 1); return; end
    req_valid = 1'b1; req_init = init; req_presc = presc;
    @(negedge clk);
    req_valid = 1'b0;
    ok = 1;
  endtask

  task automatic run_req(input logic [29:0] init, input logic [4:0] presc, input logic [31:0] n,
                         input bit stale, input int hold,
                         input logic [63:0] lit_cycles, input bit lit_to, input bit lit_match);
    logic [31:0] seq [5];
    bit ok;
    int w;
    logic [63:0] budget;
    seq[0] = 32'h8000_0000; seq[1] = 32'h8000_0000;
    seq[2] = {2'b00, init};  seq[3] = {2'b01, 25'b0, presc};
    seq[4] = 32'hC000_0000;
    stub_n = n; stub_stale = stale;
    exp_q.push_back(model(init, presc, n));
    start_req(init, presc, ok);
    if (!ok) begin void'(exp_q.pop_back()); return; end
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("tmr_cmd_seq%0d", k), tmr_cmd, seq[k]);
      chk("req_ready_busy", req_ready, 0);
      @(negedge clk);
    end
    budget = (64'(init) << presc) + 64'(SLACK) + 20;
    w = 0;
    while (!rsp_valid && 64'(w) < budget) begin
      if (req_ready) chk("req_ready_run", req_ready, 0);
      @(negedge clk); w++;
    end
    if (!rsp_valid) begin chk("rsp_valid_wait", 0, 1); void'(exp_q.pop_back()); return; end
    chk("lit_cycles", rsp_cycles, lit_cycles);
    chk("lit_timeout", rsp_timeout, lit_to);
    chk("lit_match", rsp_match, lit_match);
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'b1; req_init = 30'h155; req_presc = 5'd1;
      @(negedge clk);
      chk("rsp_valid_held", rsp_valid, 1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("req_ready_after_hs", req_ready, 1);
    stub_stale = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_tmr_cmd", tmr_cmd, 32'h8000_0000);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_fields", {rsp_cycles, rsp_expected, rsp_match, rsp_timeout}, '0);
    reset_n = 1'b1;
    @(negedge clk);

    run_req(30'd250, 5'd2, 32'd1000, 0, 0, 64'd1000, 0, 1);
    run_req(30'd500, 5'd4, 32'd8000, 0, 0, 64'd8000, 0, 1);
    run_req(30'd3,   5'd1, 32'd6,    0, 5, 64'd6,    0, 1);
    run_req(30'd10,  5'd0, NEVER,    0, 1, 64'd26,   1, 0);
    run_req(30'd8,   5'd0, 32'd5,    1, 0, 64'd5,    0, 0);
    run_req(30'd10,  5'd0, 32'd26,   0, 0, 64'd26,   0, 0);
    run_req(30'd0,   5'd3, NEVER,    0, 0, 64'd16,   1, 0);
    run_req(30'd0,   5'd0, 32'd0,    0, 0, 64'd0,    0, 1);
    run_req(30'h3FFF_FFFF, 5'd31, 32'd3, 0, 0, 64'd3, 0, 0);

    // Asynchronous reset in the middle of a run.
    stub_n = NEVER;
    start_req(30'd100, 5'd0, ok);
    repeat (20) @(negedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_tmr_cmd", tmr_cmd, 32'h8000_0000);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_req(30'd7, 5'd2, 32'd28, 0, 0, 64'd28, 0, 1);

    chk("queue_drained", 64'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
